// File: rtl/dds_pkg.sv
// Shared definitions for the four-channel DDS scheduler.
//   CH_NUM / CH_W : channel count and slot/tag width
//   PW            : phase accumulator and frequency word width
//   AW / DW       : sine ROM address and sample widths
//   FW_*          : commonly used frequency words
package dds_pkg;

    localparam int CH_NUM = 4;
    localparam int CH_W   = 2;
    localparam int PW     = 32;
    localparam int AW     = 8;
    localparam int DW     = 8;

    localparam logic [PW-1:0] FW_ZERO      = 32'h0000_0000;
    localparam logic [PW-1:0] FW_ADDR_STEP = 32'h0100_0000;  // +1 ROM address per frame
    localparam logic [PW-1:0] FW_HALF      = 32'h8000_0000;  // alternates 0x00 / 0x80
    localparam logic [PW-1:0] FW_EXAMPLE   = 32'd6710886;

    typedef logic [CH_W-1:0] ch_t;

endpackage

// File: rtl/dds_chan_sched_if.sv
// Bus bundle between the scheduler and its neighbours.
//   master : frequency-config logic, sample consumers and the external ROM
//            (drives en, cfg_*, phase_clr, rom_q; observes the rest)
//   slave  : dds_chan_sched
interface dds_chan_sched_if import dds_pkg::*; ();

    logic          en;
    logic          cfg_wr;
    ch_t           cfg_ch;
    logic [PW-1:0] cfg_fw;
    logic          cfg_rdy;
    logic          phase_clr;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_q;
    logic [DW-1:0] data_o;
    ch_t           data_ch;
    logic          data_v;
    logic          frame_o;

    modport master (
        output en, cfg_wr, cfg_ch, cfg_fw, phase_clr, rom_q,
        input  cfg_rdy, rom_addr, data_o, data_ch, data_v, frame_o
    );

    modport slave (
        input  en, cfg_wr, cfg_ch, cfg_fw, phase_clr, rom_q,
        output cfg_rdy, rom_addr, data_o, data_ch, data_v, frame_o
    );

endinterface

// File: rtl/dds_phase_acc.sv
// One DDS channel: phase accumulator plus its frequency-word register.
//   sclk, rst_n : clock, asynchronous active-low reset
//   step        : add fw to acc this cycle
//   clr         : zero acc (wins over step)
//   load        : replace fw with load_fw
//   acc, fw     : current accumulator and frequency word
module dds_phase_acc #(
    parameter int PW = 32
) (
    input  logic          sclk,
    input  logic          rst_n,
    input  logic          step,
    input  logic          clr,
    input  logic          load,
    input  logic [PW-1:0] load_fw,
    output logic [PW-1:0] acc,
    output logic [PW-1:0] fw
);

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            fw  <= '0;
        end else begin
            if (clr)
                acc <= '0;
            else if (step)
                acc <= acc + fw;  // modulo 2^PW wrap is intended
            if (load)
                fw <= load_fw;
        end
    end

endmodule

// File: rtl/dds_chan_sched.sv
// Time-multiplexes four DDS phase accumulators onto one external sine ROM.
// Each enabled cycle one channel (round-robin slot) presents its ROM address
// and advances its accumulator; the sample returns two cycles later tagged
// with its channel. Frequency-word writes and phase clears are deferred to
// the frame boundary (slot 3 with en high).
//   sclk, rst_n : clock, asynchronous active-low reset
//   bus         : slave side of dds_chan_sched_if (config handshake, phase
//                 clear, ROM address/data, tagged sample output)
module dds_chan_sched import dds_pkg::*; #(
    parameter int CH_NUM = dds_pkg::CH_NUM,
    parameter int PW     = dds_pkg::PW,
    parameter int AW     = dds_pkg::AW,
    parameter int DW     = dds_pkg::DW
) (
    input logic              sclk,
    input logic              rst_n,
    dds_chan_sched_if.slave  bus
);

    ch_t           slot;
    logic          boundary;
    logic          cfg_pend;
    ch_t           cfg_pch;
    logic [PW-1:0] cfg_pfw;
    logic          cfg_rdy_r;
    logic          clr_pend;

    logic [PW-1:0] acc_w [CH_NUM];
    logic [PW-1:0] fw_w  [CH_NUM];

    logic          vld_p0;
    ch_t           ch_p0;
    logic          vld_p1;
    ch_t           ch_p1;
    logic [DW-1:0] data_p1;
    logic          frame_p1;

    assign boundary = bus.en && (slot == CH_W'(CH_NUM - 1));

    for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
        logic unused_bits;

        dds_phase_acc #(.PW(PW)) u_acc (
            .sclk    (sclk),
            .rst_n   (rst_n),
            .step    (bus.en && (slot == CH_W'(i))),
            .clr     (boundary && clr_pend),
            .load    (boundary && cfg_pend && (cfg_pch == CH_W'(i))),
            .load_fw (cfg_pfw),
            .acc     (acc_w[i]),
            .fw      (fw_w[i])
        );

        // Only the accumulator's top bits address the ROM; fw readback is spare.
        assign unused_bits = ^{acc_w[i][PW-AW-1:0], fw_w[i]};
    end

    // Pre-increment value of the active channel; shown even while stalled.
    assign bus.rom_addr = acc_w[slot][PW-1 -: AW];
    assign bus.cfg_rdy  = cfg_rdy_r;

    // Slot counter and deferred config / clear requests.
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            slot      <= '0;
            cfg_pend  <= 1'b0;
            cfg_pch   <= '0;
            cfg_pfw   <= '0;
            cfg_rdy_r <= 1'b1;
            clr_pend  <= 1'b0;
        end else begin
            if (bus.en)
                slot <= slot + 1'b1;

            // A pulse landing on the boundary edge stays pending for the next frame.
            if (bus.phase_clr)
                clr_pend <= 1'b1;
            else if (boundary)
                clr_pend <= 1'b0;

            // cfg_rdy high implies nothing pending, so commit and accept never collide.
            if (boundary && cfg_pend) begin
                cfg_pend  <= 1'b0;
                cfg_rdy_r <= 1'b1;
            end else if (bus.cfg_wr && cfg_rdy_r) begin
                cfg_pend  <= 1'b1;
                cfg_rdy_r <= 1'b0;
                cfg_pch   <= bus.cfg_ch;
                cfg_pfw   <= bus.cfg_fw;
            end
        end
    end

    // p0: tag travelling alongside the external ROM read
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0 <= 1'b0;
            ch_p0  <= '0;
        end else begin
            vld_p0 <= bus.en;
            ch_p0  <= slot;
        end
    end

    // p1: output register; sample and tag hold while no new sample arrives
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1   <= 1'b0;
            ch_p1    <= '0;
            data_p1  <= '0;
            frame_p1 <= 1'b0;
        end else begin
            vld_p1   <= vld_p0;
            frame_p1 <= vld_p0 && (ch_p0 == '0);
            if (vld_p0) begin
                data_p1 <= bus.rom_q;
                ch_p1   <= ch_p0;
            end
        end
    end

    assign bus.data_v  = vld_p1;
    assign bus.data_ch = ch_p1;
    assign bus.data_o  = data_p1;
    assign bus.frame_o = frame_p1;

endmodule

// File: tb/tb_dds_chan_sched.sv
// Self-checking bench for dds_chan_sched: a cycle-level behavioural model of
// the scheduler, a 1-cycle-latency ROM, a per-cycle compare process and
// directed scenarios with literal expectations.
module tb_dds_chan_sched;

    logic sclk = 1'b0;
    logic rst_n = 1'b0;

    always #5 sclk = ~sclk;

    dds_chan_sched_if bus ();

    dds_chan_sched dut (
        .sclk  (sclk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic logic [7:0] rom_fn(input logic [7:0] a);
        return {a[3:0], a[7:4]} ^ 8'hA5;
    endfunction

    // External ROM: data valid one cycle after the address.
    always @(posedge sclk) bus.rom_q <= rom_fn(bus.rom_addr);

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit [31:0] m_acc [4];
    bit [31:0] m_fw  [4];
    int        m_slot = 0;
    bit        m_pcfg = 0;
    int        m_pch  = 0;
    bit [31:0] m_pfw  = 0;
    bit        m_pclr = 0;
    bit        m_rdy  = 1;
    bit        s1_v = 0;
    int        s1_ch = 0;
    bit [7:0]  s1_addr = 0;
    bit        mo_v = 0;
    bit        mo_f = 0;
    int        mo_ch = 0;
    bit [7:0]  mo_d = 0;

    function automatic bit [7:0] top_byte(input bit [31:0] v);
        return v[31:24];
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 4; i++) begin
            m_acc[i] = 0;
            m_fw[i]  = 0;
        end
        m_slot = 0; m_pcfg = 0; m_pch = 0; m_pfw = 0; m_pclr = 0; m_rdy = 1;
        s1_v = 0; s1_ch = 0; s1_addr = 0;
        mo_v = 0; mo_f = 0; mo_ch = 0; mo_d = 0;
    endtask

    task automatic m_step();
        bit bnd;
        bnd = bus.en && (m_slot == 3);
        // sample two cycles after issue
        mo_v = s1_v;
        mo_f = s1_v && (s1_ch == 0);
        if (s1_v) begin
            mo_ch = s1_ch;
            mo_d  = rom_fn(s1_addr);
        end
        s1_v    = bus.en;
        s1_ch   = m_slot;
        s1_addr = top_byte(m_acc[m_slot]);
        if (bus.en) begin
            m_acc[m_slot] = m_acc[m_slot] + m_fw[m_slot];
            m_slot = (m_slot + 1) % 4;
        end
        if (bnd && m_pclr) begin
            for (int i = 0; i < 4; i++) m_acc[i] = 0;
            m_pclr = 0;
        end
        if (bus.phase_clr) m_pclr = 1;
        if (bnd && m_pcfg) begin
            m_fw[m_pch] = m_pfw;
            m_pcfg = 0;
            m_rdy  = 1;
        end else if (bus.cfg_wr && m_rdy) begin
            m_pcfg = 1;
            m_rdy  = 0;
            m_pch  = int'(bus.cfg_ch);
            m_pfw  = bus.cfg_fw;
        end
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge sclk or negedge rst_n);
            if (!rst_n) m_reset();
            else        m_step();
        end
    end

    // ---------------- per-cycle compare ----------------
    logic [7:0] prev_q = '0;

    initial begin
        forever begin
            @(negedge sclk);
            chk("rom_addr", 32'(bus.rom_addr), 32'(top_byte(m_acc[m_slot])));
            chk("cfg_rdy",  32'(bus.cfg_rdy),  32'(m_rdy));
            chk("data_v",   32'(bus.data_v),   32'(mo_v));
            chk("frame_o",  32'(bus.frame_o),  32'(mo_f));
            chk("data_ch",  32'(bus.data_ch),  32'(mo_ch));
            chk("data_o",   32'(bus.data_o),   32'(mo_d));
            if (bus.data_v === 1'b1 && rst_n)
                chk("data_o_vs_rom_q", 32'(bus.data_o), 32'(prev_q));
            prev_q = bus.rom_q;
        end
    end

    // ---------------- driver helpers ----------------
    task automatic wait_slot(input int s);
        int n;
        n = 0;
        do begin
            @(negedge sclk);
            n++;
        end while (m_slot != s && n < 8);
        if (m_slot != s) begin
            checks++;
            errors++;
            $display("FAIL wait_slot: slot %0d not reached, at %0d", s, m_slot);
        end
    endtask

    task automatic get_addr(input int s, output logic [7:0] a);
        wait_slot(s);
        a = bus.rom_addr;
    endtask

    task automatic cfg_write(input int ch, input logic [31:0] fw);
        wait_slot(0);
        bus.cfg_wr = 1'b1;
        bus.cfg_ch = 2'(ch);
        bus.cfg_fw = fw;
        @(negedge sclk);
        bus.cfg_wr = 1'b0;
    endtask

    logic [7:0] a;
    int cnt;

    initial begin
        bus.en = 1'b0;
        bus.cfg_wr = 1'b0;
        bus.cfg_ch = '0;
        bus.cfg_fw = '0;
        bus.phase_clr = 1'b0;

        // Reset, then idle channels
        repeat (3) @(negedge sclk);
        rst_n = 1'b1;
        @(negedge sclk);
        bus.en = 1'b1;
        @(negedge sclk);
        chk("idle_v_t1", 32'(bus.data_v), 0);
        @(negedge sclk);
        chk("idle_first_v", 32'(bus.data_v), 1);
        chk("idle_first_ch", 32'(bus.data_ch), 0);
        chk("idle_first_frame", 32'(bus.frame_o), 1);
        for (int k = 1; k < 5; k++) begin
            @(negedge sclk);
            chk("idle_seq_ch", 32'(bus.data_ch), 32'(k % 4));
            chk("idle_seq_frame", 32'(bus.frame_o), (k % 4 == 0) ? 1 : 0);
            chk("idle_addr", 32'(bus.rom_addr), 0);
        end

        // Mid-frame config write of ch2
        cfg_write(2, 32'h0100_0000);
        cnt = 0;
        for (int k = 0; k < 8; k++) begin
            if (bus.cfg_rdy) break;
            cnt++;
            @(negedge sclk);
        end
        chk("cfg_rdy_low_cycles", 32'(cnt), 3);
        for (int k = 0; k < 3; k++) begin
            get_addr(2, a);
            chk("ch2_ramp", 32'(a), 32'(k));
        end
        get_addr(3, a); chk("ch3_idle", 32'(a), 0);
        get_addr(0, a); chk("ch0_idle", 32'(a), 0);
        get_addr(1, a); chk("ch1_idle", 32'(a), 0);

        // Accumulator wrap on ch1; second cycle of cfg_wr is ignored
        wait_slot(0);
        bus.cfg_wr = 1'b1;
        bus.cfg_ch = 2'd1;
        bus.cfg_fw = 32'h8000_0000;
        @(negedge sclk);
        bus.cfg_fw = 32'h1234_5678;
        @(negedge sclk);
        bus.cfg_wr = 1'b0;
        get_addr(1, a); chk("ch1_wrap0", 32'(a), 32'h00);
        get_addr(1, a); chk("ch1_wrap1", 32'(a), 32'h80);
        get_addr(1, a); chk("ch1_wrap2", 32'(a), 32'h00);

        // Clear and commit on one boundary
        cfg_write(0, 32'h0400_0000);
        for (int k = 0; k < 4; k++) begin
            get_addr(0, a);
            chk("ch0_ramp", 32'(a), 32'(4 * k));
        end
        bus.phase_clr = 1'b1;
        bus.cfg_wr = 1'b1;
        bus.cfg_ch = 2'd3;
        bus.cfg_fw = 32'h0200_0000;
        @(negedge sclk);
        bus.phase_clr = 1'b0;
        bus.cfg_wr = 1'b0;
        for (int k = 0; k < 4; k++) begin
            get_addr(k, a);
            chk("after_clear", 32'(a), 0);
        end
        get_addr(0, a); chk("clr_ch0_next", 32'(a), 32'h04);
        get_addr(3, a); chk("clr_ch3_next", 32'(a), 32'h02);

        // Stall of 5 cycles starting at slot 2, with a write pending
        cfg_write(1, 32'h4000_0000);
        wait_slot(2);
        bus.en = 1'b0;
        chk("stall_inflight0_v", 32'(bus.data_v), 1);
        chk("stall_inflight0_ch", 32'(bus.data_ch), 0);
        @(negedge sclk);
        chk("stall_inflight1_v", 32'(bus.data_v), 1);
        chk("stall_inflight1_ch", 32'(bus.data_ch), 1);
        for (int k = 0; k < 3; k++) begin
            @(negedge sclk);
            chk("stall_no_v", 32'(bus.data_v), 0);
        end
        @(negedge sclk);
        chk("stall_cfg_pending", 32'(bus.cfg_rdy), 0);
        chk("stall_ch_hold", 32'(bus.data_ch), 1);
        bus.en = 1'b1;
        @(negedge sclk);
        chk("resume_v0", 32'(bus.data_v), 0);
        @(negedge sclk);
        chk("resume_first_v", 32'(bus.data_v), 1);
        chk("resume_first_ch", 32'(bus.data_ch), 2);

        // Reset while a write is pending
        cfg_write(3, 32'h7f00_0000);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_data_v", 32'(bus.data_v), 0);
        chk("rst_data_o", 32'(bus.data_o), 0);
        chk("rst_data_ch", 32'(bus.data_ch), 0);
        chk("rst_frame_o", 32'(bus.frame_o), 0);
        chk("rst_cfg_rdy", 32'(bus.cfg_rdy), 1);
        chk("rst_rom_addr", 32'(bus.rom_addr), 0);
        @(negedge sclk);
        rst_n = 1'b1;
        for (int f = 0; f < 3; f++) begin
            for (int k = 0; k < 4; k++) begin
                get_addr(k, a);
                chk("post_rst_addr", 32'(a), 0);
            end
        end
        chk("post_rst_cfg_rdy", 32'(bus.cfg_rdy), 1);

        repeat (2) @(negedge sclk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "timeout");
    end

endmodule
